// File: rtl/memctl_pkg.sv
// memctl_pkg: shared state encoding, size codes and byte-count helper for mem_access_ctrl
package memctl_pkg;
  typedef enum logic [1:0] {IDLE, XFER, CAPTURE, DONE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: splits MOV requests into big-endian byte RAM cycles; MEMCTL_ALIGN_CHECK_EN enables misalignment trapping
module mem_access_ctrl
  import memctl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              ReadWrite,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata
);
  state_t      state;
  logic        rd, rd_valid, mis_req;
  logic [2:0]  n, cnt, n_in;
  logic [31:0] acc, wsh, wal;
  assign n_in = byte_count(size);
  // left-justify the used bytes so writes always shift out from bit 31
  assign wal = data_in << {3'd4 - n_in, 3'b000};
`ifdef MEMCTL_ALIGN_CHECK_EN
  assign mis_req = (size == SZ_HALF && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd        <= 1'b0;
      rd_valid  <= 1'b0;
      n         <= '0;
      cnt       <= '0;
      acc       <= '0;
      wsh       <= '0;
      data_out  <= '0;
      MOC       <= 1'b0;
      misalign  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      rd_valid <= ram_re;
      if (rd_valid) acc <= {acc[23:0], ram_rdata};
      case (state)
        IDLE: if (MOV) begin
          rd  <= ReadWrite;
          n   <= n_in;
          acc <= '0;
          if (mis_req) state <= DONE;
          else begin
            state     <= XFER;
            cnt       <= 3'd1;
            ram_addr  <= addr;
            ram_re    <= ReadWrite;
            ram_we    <= !ReadWrite;
            ram_wdata <= wal[31:24];
            wsh       <= wal << 8;
          end
        end
        XFER: if (cnt == n) begin
          ram_re <= 1'b0;
          ram_we <= 1'b0;
          MOC    <= !rd;
          state  <= rd ? CAPTURE : DONE;
        end else begin
          cnt       <= cnt + 3'd1;
          ram_addr  <= ram_addr + ADDR_W'(1);
          ram_wdata <= wsh[31:24];
          wsh       <= wsh << 8;
        end
        CAPTURE: begin
          data_out <= {acc[23:0], ram_rdata};
          MOC      <= 1'b1;
          state    <= DONE;
        end
        DONE: if (!MOC) begin
          // only a trapped misaligned request reaches DONE with MOC still low
          MOC      <= 1'b1;
          misalign <= 1'b1;
        end else if (!MOV) begin
          MOC      <= 1'b0;
          misalign <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access sequencer between the microprogrammed control unit and the byte-wide main RAM. It accepts one memory operation per MOV assertion, using the latched MAR address, MDR data, ReadWrite and access size. It splits the operation into sequential single-byte RAM cycles in big-endian order and returns MOC when the operation is complete. The control unit's MOC wait microstates (inverter mux input 00) stall on this block's MOC.

## Interface

Parameters:
- ADDR_W, 8, RAM byte-address width; RAM holds 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- MOV  in  1  memory operation valid, from control unit.
- ReadWrite  in  1  1 = read, 0 = write.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- addr  in  ADDR_W  byte address (MAR output).
- data_in  in  32  write data (MDR output); low bytes used for byte/halfword.
- data_out  out  32  read result, zero-extended; feeds MDR input mux.
- MOC  out  1  memory operation complete.
- misalign  out  1  alignment error flag (only with ALIGN_CHECK_EN).
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  8  RAM read byte, valid one cycle after ram_re.

## Operation

- States: IDLE, XFER, CAPTURE, DONE.
- IDLE:
  - On MOV=1, latch addr, size, ReadWrite and data_in.
  - Set byte count N: byte 1, halfword 2, word/11 4.
  - Clear index i; go to XFER.
- XFER:
  - Each cycle, issue byte i with ram_addr = base + i, mod 2^ADDR_W.
  - Read: ram_re=1. Write: ram_we=1, ram_wdata = byte (N-1-i) of the latched data, MSB first.
  - Read: capture ram_rdata from the previous issue by shifting it into an accumulator (acc = acc<<8 | ram_rdata).
  - After issuing byte N-1: read goes to CAPTURE, write goes to DONE.
- CAPTURE: shift in the last byte; drive data_out = accumulator, zero-extended; go to DONE.
- DONE:
  - MOC=1; data_out held.
  - Stay in DONE while MOV=1.
  - When MOV=0, go to IDLE; MOC falls on that edge.
- MOV dropped during XFER/CAPTURE: the transfer still completes, and MOC pulses for exactly one cycle.
- Write leaves data_out unchanged.
- ram_we and ram_re are never both high. Both are 0 outside XFER.

## Timing

- Reset values:
  - All outputs 0; state IDLE; accumulator 0.
  - Reset mid-transfer aborts immediately. No further RAM strobes are issued on the cycle after the reset edge.
- Latency (E0 = edge sampling MOV=1 in IDLE):
  - Writes: MOC rises on edge E0+N.
  - Reads: MOC rises on edge E0+N+1.
  - Byte write 1 cycle; word write 4; byte read 2; halfword read 3; word read 5.
- RAM strobes are asserted in cycles E0..E0+N-1. They are registered outputs.
- Back-to-back operations need MOV low for at least one cycle. MOV held high in DONE does not retrigger.

## Configuration

- MEMCTL_ALIGN_CHECK_EN defined:
  - In IDLE, a halfword with addr[0]=1, or a word with addr[1:0]≠00, issues no RAM strobes.
  - It goes directly to DONE on E0, so MOC rises on E0+1.
  - misalign=1 while in DONE; data_out unchanged.
  - misalign clears on exit from DONE.
- MEMCTL_ALIGN_CHECK_EN undefined:
  - Any address is accepted; byte addresses wrap modulo 2^ADDR_W.
  - misalign is tied to 0.

## Structure

- Package memctl_pkg holds:
  - state enum (IDLE, XFER, CAPTURE, DONE);
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - a function returning byte count from size.
- Single module; no sub-module. Byte count/index, the accumulator and the write-byte select are local logic.

## Test plan

- Word write: addr=0x10, data_in=0xDEADBEEF.
  - RAM[0x10..0x13] = DE,AD,BE,EF.
  - MOC high at E0+4, held until MOV drops.
- Word read: RAM[0x10..0x13] = 01,23,45,67.
  - data_out=0x01234567 at E0+5 with MOC=1.
  - Exactly 4 ram_re pulses.
- Byte and halfword read of RAM[0x21]=0x80, RAM[0x22]=0x7F:
  - Byte at 0x21 gives data_out=0x00000080.
  - Halfword at 0x22 (with RAM[0x23]=0x01) gives 0x00007F01.
- Wrap: word write at addr=0xFE (ADDR_W=8, check disabled) writes 0xFE, 0xFF, 0x00, 0x01 in order.
- Reset asserted on E0+2 of a word write:
  - All outputs 0 after the reset edge; only 2 bytes written.
  - The next MOV starts cleanly.
- MEMCTL_ALIGN_CHECK_EN, word read at 0x11:
  - No RAM strobes.
  - MOC=1 and misalign=1 at E0+1.
  - Both clear after MOV drops.
